// File: rtl/flags_unit.sv
// rtl/flags_unit.sv - NZCV condition-flag producer with LATENCY-deep pipeline and flags register.
// Optional shadow save/restore enabled by defining FLAGS_SAVE_EN.
module flags_unit #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic             op_set_flags,
  input  logic [1:0]       op_kind,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic [WIDTH-1:0] result,
  input  logic             shift_carry,
  input  logic             flush,
  input  logic             save_req,
  input  logic             restore_req,
  output logic [3:0]       flags,
  output logic             flags_busy,
  output logic             flags_commit
);
  localparam int NSTG = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int MSB  = WIDTH - 1;

  // Entry layout: {Z, C, N, V, is_logic}; is_logic defers V to the commit edge.
  logic             accept;
  logic [4:0]       entry;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] r;
  logic             c_bit;
  logic             v_bit;

  always_comb begin
    accept = op_valid && op_set_flags && (op_kind != 2'b11);
    sum    = {1'b0, operand_a} + {1'b0, operand_b};
    diff   = {1'b0, operand_a} + {1'b0, ~operand_b} + {{WIDTH{1'b0}}, 1'b1};
    r      = result;
    c_bit  = shift_carry;
    v_bit  = 1'b0;
    case (op_kind)
      2'b01: begin
        r     = sum[WIDTH-1:0];
        c_bit = sum[WIDTH];
        v_bit = (operand_a[MSB] == operand_b[MSB]) && (sum[MSB] != operand_a[MSB]);
      end
      2'b10: begin
        r     = diff[WIDTH-1:0];
        c_bit = diff[WIDTH];
        v_bit = (operand_a[MSB] != operand_b[MSB]) && (diff[MSB] != operand_a[MSB]);
      end
      default: ;
    endcase
    entry = {(r == '0), c_bit, r[MSB], v_bit, (op_kind == 2'b00)};
  end

  logic [NSTG-1:0] stg_valid;
  logic [NSTG-1:0] valid_next;
  logic [4:0]      stg_data [NSTG];
  logic            cm_valid;
  logic [4:0]      cm_data;

  always_comb begin
    valid_next[0] = accept && !flush;
    for (int i = 1; i < NSTG; i++) valid_next[i] = stg_valid[i-1] && !flush;
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign cm_valid = accept;
      assign cm_data  = entry;
    end else begin : g_piped
      assign cm_valid = stg_valid[NSTG-1];
      assign cm_data  = stg_data[NSTG-1];
    end
  endgenerate

  logic       do_commit;
  logic [3:0] new_flags;
  logic       restore_hit;

  assign do_commit = cm_valid && !flush;
  assign new_flags = {cm_data[4:2], cm_data[0] ? flags[0] : cm_data[1]};

`ifdef FLAGS_SAVE_EN
  logic [3:0] shadow;
  assign restore_hit = restore_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) shadow <= 4'b0000;
    else if (save_req) shadow <= flags;
  end
`else
  logic unused_save_ports;
  assign unused_save_ports = save_req | restore_req;
  assign restore_hit       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid    <= '0;
      for (int i = 0; i < NSTG; i++) stg_data[i] <= 5'b0;
      flags        <= 4'b0000;
      flags_busy   <= 1'b0;
      flags_commit <= 1'b0;
    end else begin
      stg_valid   <= valid_next;
      stg_data[0] <= entry;
      for (int i = 1; i < NSTG; i++) stg_data[i] <= stg_data[i-1];
      flags_busy  <= (LATENCY > 1) && (|valid_next);
      flags_commit <= do_commit && !restore_hit;
`ifdef FLAGS_SAVE_EN
      if (restore_hit) flags <= shadow;
      else if (do_commit) flags <= new_flags;
`else
      if (do_commit) flags <= new_flags;
`endif
    end
  end
endmodule
